aes_inv_round_iter: RTL

- Iterative AES-128 inverse-cipher core, one round per clock.
- Accepts a 128-bit ciphertext on a valid/ready handshake and fetches round keys by index from an external key-schedule store.
- Per round it applies InvShiftRows, then the existing 16-byte inverse S-box layer, then AddRoundKey, then InvMixColumns.
- Sits directly upstream and downstream of the inverse S-box layer, sequencing and feeding it; delivers plaintext on a valid/ready output.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_inv_round_iter_if.sv | 25 ++
 rtl/aes_inv_mix_columns.sv | 19 +
 rtl/aes_inv_sbox_layer.sv | 11 +
 rtl/aes_inv_round_iter.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, byte addressing and GF(2^8) arithmetic for the inverse-cipher core.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NR      = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    // Byte (row, col) sits at index 4*col+row, byte 0 in the top bits of the block.
    function automatic int aes_byte_lsb(input int row, input int col);
        return AES_BLOCK_W - 8 - 8 * (4 * col + row);
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] aes_inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

endpackage

// File: rtl/aes_inv_round_iter_if.sv
// Ciphertext/plaintext handshakes plus the round-key lookup port of aes_inv_round_iter.
interface aes_inv_round_iter_if
    import aes_pkg::*;
#(
    parameter int RK_IDX_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_data;
    logic [RK_IDX_W-1:0]    rk_idx;
    logic [AES_BLOCK_W-1:0] rk_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );
endinterface

// File: rtl/aes_inv_mix_columns.sv
// Combinational InvMixColumns over four columns, coefficients 0e/0b/0d/09.
module aes_inv_mix_columns
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] data_i,
    output logic [AES_BLOCK_W-1:0] data_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_i[aes_byte_lsb(0, c) +: 8];
        assign a1 = data_i[aes_byte_lsb(1, c) +: 8];
        assign a2 = data_i[aes_byte_lsb(2, c) +: 8];
        assign a3 = data_i[aes_byte_lsb(3, c) +: 8];
        assign data_o[aes_byte_lsb(0, c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign data_o[aes_byte_lsb(1, c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign data_o[aes_byte_lsb(2, c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign data_o[aes_byte_lsb(3, c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
endmodule

// File: rtl/aes_inv_sbox_layer.sv
// Sixteen parallel AES inverse S-boxes over a 128-bit block.
module aes_inv_sbox_layer
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] data_i,
    output logic [AES_BLOCK_W-1:0] data_o
);
    for (genvar b = 0; b < 16; b++) begin : g_byte
        assign data_o[8*b +: 8] = aes_inv_sbox(data_i[8*b +: 8]);
    end
endmodule

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 inverse cipher, one round per clock. Defining AES_INV_SBOX_REG_EN
// registers the S-box output so every ROUND/FINAL step spans two phases.
module aes_inv_round_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int RK_IDX_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    aes_inv_round_iter_if.slave bus
);
    localparam logic [RK_IDX_W-1:0] KEY_LAST  = RK_IDX_W'(NUM_ROUNDS);
    localparam logic [RK_IDX_W-1:0] CNT_FIRST = RK_IDX_W'(NUM_ROUNDS - 1);
    localparam logic [RK_IDX_W-1:0] CNT_ONE   = RK_IDX_W'(1);

    aes_state_e             state_q, state_d;
    logic [RK_IDX_W-1:0]    cnt_q, cnt_d, rk_idx_s;
    logic [AES_BLOCK_W-1:0] data_q, data_d, out_data_q, out_data_d;
    logic [AES_BLOCK_W-1:0] isr_s, isb_s, ark_s, imc_s;
    logic                   step_s;
`ifdef AES_INV_SBOX_REG_EN
    logic                   phase_q, phase_d;
    logic [AES_BLOCK_W-1:0] sbox_q, sbox_d;
`endif

    // InvShiftRows: output (r, c) takes input (r, (c - r) mod 4), i.e. row r rotates right by r.
    for (genvar r = 0; r < 4; r++) begin : g_isr_row
        for (genvar c = 0; c < 4; c++) begin : g_isr_col
            assign isr_s[aes_byte_lsb(r, c) +: 8] = data_q[aes_byte_lsb(r, (c + 4 - r) % 4) +: 8];
        end
    end

    aes_inv_sbox_layer u_sbox (.data_i(isr_s), .data_o(isb_s));

`ifdef AES_INV_SBOX_REG_EN
    assign ark_s  = sbox_q ^ bus.rk_data;
    assign step_s = phase_q;
`else
    assign ark_s  = isb_s ^ bus.rk_data;
    assign step_s = 1'b1;
`endif

    aes_inv_mix_columns u_imc (.data_i(ark_s), .data_o(imc_s));

    // Next-state and datapath update for the round sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        out_data_d = out_data_q;
`ifdef AES_INV_SBOX_REG_EN
        phase_d    = 1'b0;
        sbox_d     = sbox_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data ^ bus.rk_data;
                    cnt_d   = CNT_FIRST;
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (step_s) begin
                    data_d = imc_s;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FINAL;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_FINAL: begin
                if (step_s) begin
                    out_data_d = ark_s;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_FINAL;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AES_INV_SBOX_REG_EN
        if ((state_q == ST_ROUND) || (state_q == ST_FINAL)) begin
            phase_d = ~phase_q;
            sbox_d  = isb_s;
        end else begin
            phase_d = 1'b0;
        end
`endif
    end

    // Round-key index is a pure decode of registered state so it never glitches.
    always_comb begin
        rk_idx_s = KEY_LAST;
        case (state_q)
            ST_IDLE:  rk_idx_s = KEY_LAST;
            ST_ROUND: rk_idx_s = cnt_q;
            ST_FINAL: rk_idx_s = {RK_IDX_W{1'b0}};
            ST_DONE:  rk_idx_s = KEY_LAST;
            default:  rk_idx_s = KEY_LAST;
        endcase
    end

    // State, counter and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_FIRST;
            data_q     <= {AES_BLOCK_W{1'b0}};
            out_data_q <= {AES_BLOCK_W{1'b0}};
`ifdef AES_INV_SBOX_REG_EN
            phase_q    <= 1'b0;
            sbox_q     <= {AES_BLOCK_W{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            out_data_q <= out_data_d;
`ifdef AES_INV_SBOX_REG_EN
            phase_q    <= phase_d;
            sbox_q     <= sbox_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_data_q;
    assign bus.rk_idx    = rk_idx_s;

endmodule
